// File: rtl/puf_soc_meas_ctrl.sv
// Purpose: sequences one PUF RO-pair measurement (select, settle, snapshot, count window, drain, compare).
// Latency: o_done arrives 2*SETTLE_CYCLES+3+max(win,1) cycles after the accepted start.
// Backpressure: none; starts are ignored while busy, and abort returns to IDLE with results untouched.
module puf_soc_meas_ctrl #(
    parameter int CNT_BIT_SIZE  = 32,
    parameter int WIN_BIT_SIZE  = 16,
    parameter int SEL_BIT_SIZE  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [SEL_BIT_SIZE-1:0] i_chal,
    input  logic [WIN_BIT_SIZE-1:0] i_win_len,
    output logic [SEL_BIT_SIZE-1:0] o_sel,
    output logic                    o_cnt_en,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_a,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_b,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_resp,
    output logic                    o_tie,
    output logic [CNT_BIT_SIZE-1:0] o_diff
);

    typedef enum logic [2:0] {
        IDLE, SELECT, BASE, COUNT, DRAIN, CALC, DONE
    } state_t;

    localparam logic [3:0]              SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [WIN_BIT_SIZE-1:0] WIN_ONE     = WIN_BIT_SIZE'(1);

    state_t                  state;
    logic [3:0]              settle_cnt;
    logic [WIN_BIT_SIZE-1:0] win_q;
    logic [WIN_BIT_SIZE-1:0] win_cnt;
    logic [CNT_BIT_SIZE-1:0] base_a;
    logic [CNT_BIT_SIZE-1:0] base_b;
    logic [CNT_BIT_SIZE-1:0] delta_a;
    logic [CNT_BIT_SIZE-1:0] delta_b;

    // Measurement FSM; every output is a register so the counters see a glitch-free enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            win_q      <= '0;
            win_cnt    <= '0;
            base_a     <= '0;
            base_b     <= '0;
            delta_a    <= '0;
            delta_b    <= '0;
            o_sel      <= '0;
            o_cnt_en   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_resp     <= 1'b0;
            o_tie      <= 1'b0;
            o_diff     <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_abort && (state != IDLE)) begin
                // Abort leaves o_sel and the previous results in place.
                state    <= IDLE;
                o_cnt_en <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            o_sel      <= i_chal;
                            // A zero-length window still counts for one cycle.
                            win_q      <= (i_win_len == '0) ? WIN_ONE : i_win_len;
                            settle_cnt <= SETTLE_LAST;
                            o_busy     <= 1'b1;
                            state      <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (settle_cnt == 4'd0) state <= BASE;
                        else settle_cnt <= settle_cnt - 4'd1;
                    end
                    BASE: begin
                        base_a   <= i_cnt_a;
                        base_b   <= i_cnt_b;
                        win_cnt  <= win_q - WIN_ONE;
                        o_cnt_en <= 1'b1;
                        state    <= COUNT;
                    end
                    COUNT: begin
                        if (win_cnt == '0) begin
                            o_cnt_en   <= 1'b0;
                            settle_cnt <= SETTLE_LAST;
                            state      <= DRAIN;
                        end else begin
                            win_cnt <= win_cnt - WIN_ONE;
                        end
                    end
                    DRAIN: begin
                        if (settle_cnt == 4'd0) state <= CALC;
                        else settle_cnt <= settle_cnt - 4'd1;
                    end
                    CALC: begin
                        // Modular subtraction makes a counter wrap transparent.
                        delta_a <= i_cnt_a - base_a;
                        delta_b <= i_cnt_b - base_b;
                        state   <= DONE;
                    end
                    DONE: begin
                        o_resp <= (delta_a > delta_b);
                        o_tie  <= (delta_a == delta_b);
                        o_diff <= (delta_a > delta_b) ? (delta_a - delta_b) : (delta_b - delta_a);
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_soc_meas_ctrl.sv
// Purpose: self-checking bench for puf_soc_meas_ctrl using directed vectors and a simple RO counter model.
// Latency: checks edge-exact timing of enable window and done pulse against hand-computed values.
// Backpressure: covers abort, held start, back-to-back restart and asynchronous reset.
module tb_puf_soc_meas_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [3:0]  i_chal = '0;
    logic [15:0] i_win_len = '0;
    logic [3:0]  o_sel;
    logic        o_cnt_en;
    logic [31:0] cnt_a, cnt_b;
    logic        o_busy, o_done, o_resp, o_tie;
    logic [31:0] o_diff;

    puf_soc_meas_ctrl #(
        .CNT_BIT_SIZE(32), .WIN_BIT_SIZE(16), .SEL_BIT_SIZE(4), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_chal(i_chal), .i_win_len(i_win_len), .o_sel(o_sel), .o_cnt_en(o_cnt_en),
        .i_cnt_a(cnt_a), .i_cnt_b(cnt_b), .o_busy(o_busy), .o_done(o_done),
        .o_resp(o_resp), .o_tie(o_tie), .o_diff(o_diff)
    );

    always #5 clk = ~clk;

    // RO counter model: preload on demand, otherwise step while enabled.
    logic        load = 1'b0;
    logic [31:0] load_a = '0, load_b = '0, step_a = '0, step_b = '0;
    logic        bonus_a = 1'b0;
    int          en_seen;
    always @(posedge clk) begin
        if (load) begin
            cnt_a   <= load_a;
            cnt_b   <= load_b;
            en_seen <= 0;
        end else if (o_cnt_en) begin
            cnt_a   <= cnt_a + step_a + ((bonus_a && en_seen[0]) ? 32'd1 : 32'd0);
            cnt_b   <= cnt_b + step_b;
            en_seen <= en_seen + 1;
        end
    end

    typedef struct {
        logic [3:0]  chal;
        logic [15:0] win;
        logic [31:0] ia, ib, sa, sb;
        logic        bon;
        logic        resp, tie;
        logic [31:0] diff;
    } vec_t;
    vec_t vecs[5];

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic preload(input logic [31:0] ia, ib, sa, sb, input logic bon);
        load_a = ia; load_b = ib; step_a = sa; step_b = sb; bonus_a = bon;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Issues a one-cycle start (edge 0), then scrambles the inputs that must already be latched.
    task automatic start_meas(input logic [3:0] chal, input logic [15:0] win);
        i_chal = chal; i_win_len = win; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_chal = ~chal; i_win_len = win + 16'd5;
    endtask

    // k counts edges after the start edge; values seen #1 after edge k.
    task automatic wait_done(output int done_k, output int en_first, output int en_cnt);
        done_k = -1; en_first = -1; en_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (o_cnt_en) begin
                if (en_cnt == 0) en_first = k;
                en_cnt++;
            end
            if (o_done) begin
                done_k = k;
                break;
            end
        end
    endtask

    function automatic logic [40:0] outs();
        return {o_sel, o_cnt_en, o_busy, o_done, o_resp, o_tie, o_diff};
    endfunction

    initial begin
        int dk, ef, ec, w, dones, lowbusy, toggles;
        logic [40:0] snap;

        vecs[0] = '{4'd5,  16'd10, 32'd1000,       32'd2000, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 32'd5};
        vecs[1] = '{4'd3,  16'd2,  32'hFFFF_FFFA,  32'd100,  32'd5, 32'd2, 1'b0, 1'b1, 1'b0, 32'd6};
        vecs[2] = '{4'd9,  16'd7,  32'd50,         32'd60,   32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[3] = '{4'd12, 16'd3,  32'd0,          32'd0,    32'd1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd6};
        vecs[4] = '{4'd15, 16'd0,  32'd7,          32'd7,    32'd2, 32'd1, 1'b0, 1'b1, 1'b0, 32'd1};

        #2;
        check("reset_outputs", 64'(outs()), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed measurement table.
        for (int i = 0; i < 5; i++) begin
            w = (vecs[i].win == 16'd0) ? 1 : int'(vecs[i].win);
            preload(vecs[i].ia, vecs[i].ib, vecs[i].sa, vecs[i].sb, vecs[i].bon);
            start_meas(vecs[i].chal, vecs[i].win);
            check($sformatf("v%0d_sel", i), 64'(o_sel), 64'(vecs[i].chal));
            check($sformatf("v%0d_busy_rise", i), 64'(o_busy), 64'd1);
            wait_done(dk, ef, ec);
            check($sformatf("v%0d_en_first", i), 64'(ef), 64'(S + 1));
            check($sformatf("v%0d_en_cycles", i), 64'(ec), 64'(w));
            check($sformatf("v%0d_done_edge", i), 64'(dk), 64'(2 * S + 3 + w));
            check($sformatf("v%0d_resp", i), 64'(o_resp), 64'(vecs[i].resp));
            check($sformatf("v%0d_tie", i), 64'(o_tie), 64'(vecs[i].tie));
            check($sformatf("v%0d_diff", i), 64'(o_diff), 64'(vecs[i].diff));
            check($sformatf("v%0d_busy_fall", i), 64'(o_busy), 64'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), 64'(o_done), 64'd0);
        end

        // Abort during COUNT: no done, results from the last vector retained.
        preload(32'd0, 32'd0, 32'd1, 32'd3, 1'b0);
        start_meas(4'd6, 16'd20);
        for (int k = 0; k < 50 && !o_cnt_en; k++) begin
            @(posedge clk); #1;
        end
        check("abort_reach_count", 64'(o_cnt_en), 64'd1);
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_idle", 64'({o_busy, o_cnt_en, o_done}), 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_results_kept", 64'({o_resp, o_tie, o_diff}), 64'({1'b1, 1'b0, 32'd1}));

        // Abort and start together in IDLE: abort wins.
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        check("abort_beats_start", 64'(o_busy), 64'd0);

        // Start held high for the whole measurement: one run only.
        preload(32'd50, 32'd60, 32'd1, 32'd1, 1'b0);
        i_chal = 4'd9; i_win_len = 16'd7; i_start = 1'b1;
        @(posedge clk); #1;
        dk = -1; lowbusy = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (o_done) begin
                dk = k;
                break;
            end
            if (!o_busy) lowbusy++;
        end
        i_start = 1'b0;
        check("held_done_edge", 64'(dk), 64'(2 * S + 3 + 7));
        check("held_busy_steady", 64'(lowbusy), 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        check("held_single_run", 64'(dones), 64'd0);

        // Restart in the cycle right after o_done.
        preload(32'd0, 32'd0, 32'd1, 32'd3, 1'b0);
        start_meas(4'd12, 16'd3);
        wait_done(dk, ef, ec);
        check("restart_first_done", 64'(dk), 64'(2 * S + 6));
        i_chal = 4'd10; i_win_len = 16'd3; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("restart_accepted", 64'({o_busy, o_sel}), 64'({1'b1, 4'd10}));
        wait_done(dk, ef, ec);
        check("restart_done_edge", 64'(dk), 64'(2 * S + 6));
        check("restart_result", 64'({o_resp, o_tie, o_diff}), 64'({1'b0, 1'b0, 32'd6}));

        // Asynchronous reset mid-COUNT clears everything at once.
        preload(32'd1000, 32'd2000, 32'd1, 32'd1, 1'b1);
        start_meas(4'd5, 16'd10);
        for (int k = 0; k < 50 && !o_cnt_en; k++) begin
            @(posedge clk); #1;
        end
        check("rst_reach_count", 64'(o_cnt_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_count", 64'(outs()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        snap = outs();
        toggles = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (outs() !== snap) toggles++;
            snap = outs();
        end
        check("post_rst_quiet", 64'(toggles), 64'd0);
        check("post_rst_zero", 64'(outs()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
